// File: rtl/product_acc_pkg.sv
// product_accumulator shared types and constants.
// Optional build macro ACC_SATURATE_EN selects saturating accumulation.
package product_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } acc_state_t;

  localparam int PROD_W   = 4;
  localparam int PROD_MAX = 9;

  // Counter must hold COUNT itself after the last accept.
  function automatic int cnt_w(input int count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/product_acc_if.sv
// Product-in / sum-out valid/ready bundle for product_accumulator.
// master drives products and takes sums; slave is the accumulator.
interface product_acc_if #(
  parameter int ACC_W = 8
);
  import product_acc_pkg::*;

  logic [PROD_W-1:0] prod;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  sum;
  logic              sum_valid;
  logic              sum_ready;
  logic              ovf;

  modport master (
    output prod,
    output prod_valid,
    input  prod_ready,
    input  sum,
    input  sum_valid,
    output sum_ready,
    input  ovf
  );

  modport slave (
    input  prod,
    input  prod_valid,
    output prod_ready,
    output sum,
    output sum_valid,
    input  sum_ready,
    output ovf
  );

endinterface

// File: rtl/product_accumulator_batch_counter.sv
// Per-batch accept counter; flags the final product of a batch.
// Cleared on reset, abort and when the finished sum is drained.
module batch_counter
  import product_acc_pkg::*;
#(
  parameter int COUNT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  input  logic i_drain,
  output logic o_last
);

  localparam int CNT_W = cnt_w(COUNT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr || i_drain) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_last = (r_cnt == CNT_W'(COUNT - 1));

endmodule

// File: rtl/product_accumulator.sv
// Sums COUNT multiplier products per batch, presents sum + overflow flag.
// Build macro ACC_SATURATE_EN: clamp on overflow instead of wrapping.
module product_accumulator
  import product_acc_pkg::*;
#(
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  product_acc_if.slave  bus
);

  acc_state_t       r_state;
  logic [ACC_W-1:0] r_acc;
  logic             r_ovf;

  logic             w_prod_ready;
  logic             w_accept;
  logic             w_drain;
  logic             w_last;
  logic [ACC_W:0]   w_add;
  logic             w_carry;
  logic [ACC_W-1:0] w_next;

  // Ready is pure state decode; clr/rst gate it so aborts drop nothing.
  assign w_prod_ready = (r_state == ACCUM) & ~clr & ~rst;
  assign w_accept     = bus.prod_valid & w_prod_ready;
  assign w_drain      = (r_state == DONE) & bus.sum_ready;

  assign w_add   = {1'b0, r_acc} + (ACC_W + 1)'(bus.prod);
  assign w_carry = w_add[ACC_W];

`ifdef ACC_SATURATE_EN
  assign w_next = w_carry ? '1 : w_add[ACC_W-1:0];
`else
  assign w_next = w_add[ACC_W-1:0];
`endif

  batch_counter #(
    .COUNT (COUNT)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (clr),
    .i_inc   (w_accept),
    .i_drain (w_drain),
    .o_last  (w_last)
  );

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        ACCUM: begin
          if (w_accept) begin
            r_acc <= w_next;
            r_ovf <= r_ovf | w_carry;
            if (w_last) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (bus.sum_ready) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

  assign bus.prod_ready = w_prod_ready;
  assign bus.sum_valid  = (r_state == DONE);
  assign bus.sum        = r_acc;
  assign bus.ovf        = r_ovf;

endmodule

// File: doc/product_accumulator.md
# product_accumulator

Sequential consumer sitting directly downstream of the 2-bit×2-bit combinational multiplier. It accepts the 4-bit product over a valid/ready handshake, sums a fixed batch of COUNT products into an ACC_W-bit accumulator, then presents the batch sum with an overflow flag on a second valid/ready handshake. Together the two blocks form a small multiply-accumulate (dot-product) path.

## Interface
- ACC_W, 8: accumulator and sum width in bits; legal range 4..16.
- COUNT, 4: products per batch; legal range 1..255.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous batch abort; lower priority than rst.
- prod  in  4  product from the multiplier, unsigned.
- prod_valid  in  1  prod is valid this cycle.
- prod_ready  out  1  block accepts prod this cycle.
- sum  out  ACC_W  batch sum, registered.
- sum_valid  out  1  sum and ovf are valid.
- sum_ready  in  1  downstream takes sum this cycle.
- ovf  out  1  batch sum exceeded 2^ACC_W−1 at some accumulation step.

## Operation
- Two states: ACCUM and DONE.
- ACCUM: prod_ready=1, sum_valid=0.
  - Accept when prod_valid&prod_ready: acc ← acc+prod, cnt ← cnt+1.
  - Any carry out of ACC_W sets ovf, which stays set for the rest of the batch.
  - If the accepted product is number COUNT (cnt==COUNT−1 before the increment), go to DONE.
- DONE: prod_ready=0, sum_valid=1; sum, ovf and acc are held.
  - sum_ready=1: clear acc, cnt and ovf; go to ACCUM.
  - sum_ready=0: stay in DONE with all outputs stable.
- Addition is zero-extended: prod is widened to ACC_W before adding.
- cnt is ceil(log2(COUNT+1)) bits wide. cnt never wraps, because it is cleared on leaving DONE.
- clr, in any state: acc, cnt and ovf ← 0; state ← ACCUM. A product presented in the same cycle is not accepted, so prod_ready is forced to 0 while clr=1.
- rst: same clearing effect as clr, with highest priority.
- prod_valid while in DONE is ignored; no data is lost because prod_ready=0.
- Upstream must hold prod stable while prod_valid=1 and prod_ready=0.

## Timing
- Reset values: prod_ready=0 during rst, 1 on the first cycle after rst; sum=0; sum_valid=0; ovf=0; state=ACCUM.
- prod_ready and sum_valid are decoded directly from registered state, with the clr gate noted above. There is no combinational path from prod_valid to prod_ready, or from sum_ready to sum_valid.
- Latency: the product accepted at edge N makes sum_valid=1 in the cycle after edge N.
- sum equals acc, a registered value that is valid in the same cycle as sum_valid.
- Throughput: COUNT+1 cycles per batch minimum, because the DONE state occupies at least one cycle.
- After the DONE handshake, prod_ready=1 in the very next cycle.
- COUNT=1: every accepted product goes straight to DONE.

## Configuration
- ACC_SATURATE_EN defined: on overflow, acc clamps to 2^ACC_W−1 and further additions keep it at that value; ovf is still set.
- ACC_SATURATE_EN undefined: acc wraps modulo 2^ACC_W; ovf is set.
- Handshake behaviour and timing are identical in both builds.

## Structure
- Shared package product_acc_pkg contains:
  - state enum acc_state_t {ACCUM, DONE};
  - localparam PROD_W=4, the multiplier product width;
  - localparam PROD_MAX=9, the largest 2×2-bit product.
- One natural sub-module: batch_counter. It holds cnt, increments on accept, clears on clr/rst/drain, and outputs last = (cnt==COUNT−1).
- The adder, saturation logic and FSM stay in the top module.

## Test plan
- Reset, then 4 products 3,2,6,1 with prod_valid held high (ACC_W=8, COUNT=4):
  - expect sum_valid in the cycle after the 4th accept, sum=12, ovf=0;
  - with sum_ready=1, prod_ready=1 on the next cycle.
- Backpressure: hold sum_ready=0 for 5 cycles in DONE.
  - sum stays 12, prod_ready stays 0;
  - prod_valid=1 with prod=9 during this time is not accepted, and the next batch starts from 0.
- Overflow with ACC_W=5, COUNT=4, products 9,9,9,9 (true sum 36):
  - ACC_SATURATE_EN undefined: sum=4, ovf=1.
  - ACC_SATURATE_EN defined: sum=31, ovf=1.
- clr after 2 accepted products (9,9), then 4 products of 1:
  - expect sum=4, ovf=0;
  - prod_ready=0 during the clr cycle.
- rst asserted for 1 cycle while in DONE with sum=12: all outputs go to their reset values the next cycle.
- Gapped prod_valid (1 cycle on, 2 off) with COUNT=1, products 4 then 6:
  - two separate DONE handshakes with sum=4, then sum=6;
  - no product is dropped or double-counted.
